// File: rtl/hazard_ctrl_multicycle.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_multicycle
//
// Hazard controller for a 5-stage (F/D/E/M/W) pipeline. It sits beside the
// pipeline registers and drives their stall and flush enables.
//
// Functions:
//   - Operand forwarding selects for E. M has priority over W, and x0 is never
//     forwarded.
//   - Load-use bubbles of LOAD_BUBBLES cycles. The PC and F/D are held while
//     D/E is cleared.
//   - Taken-branch flush of F/D and D/E.
//   - Data-memory wait state. It freezes F..M and bubbles W until memory
//     signals ready.
//   - A saturating count of cycles in which the PC was held.
//
// Parameters:
//   REG_AW        register address width
//   NUM_SRC       source operands per instruction
//   LOAD_BUBBLES  bubble cycles per load-use hazard (>= 1)
//   CNT_W         width of the stall-cycle counter
//
// Ports:
//   iClk, iRst                 clock, synchronous active-high reset
//   iIsLoadE, iRegWriteEn{E,M,W}, iDestReg{E,M,W}
//                              producer information per stage
//   iSrcRegD, iSrcRegE         flattened source registers, operand k at
//                              [k*REG_AW +: REG_AW]
//   iBranchTakenE              branch in E resolved taken
//   iMemReqM, iMemReadyM       data-memory handshake from M
//   oForwardE                  per operand: 00 regfile, 01 from M, 10 from W
//   oStall{F,D,E,M}            hold enables
//   oFlush{D,E,W}              clear enables (insert NOP)
//   oStallCount                cycles with oStallF=1 since reset, saturating
// -----------------------------------------------------------------------------
module hazard_ctrl_multicycle #(
    parameter int REG_AW       = 5,
    parameter int NUM_SRC      = 2,
    parameter int LOAD_BUBBLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic                      iClk,
    input  logic                      iRst,
    input  logic                      iIsLoadE,
    input  logic                      iRegWriteEnE,
    input  logic                      iRegWriteEnM,
    input  logic                      iRegWriteEnW,
    input  logic [REG_AW-1:0]         iDestRegE,
    input  logic [REG_AW-1:0]         iDestRegM,
    input  logic [REG_AW-1:0]         iDestRegW,
    input  logic [NUM_SRC*REG_AW-1:0] iSrcRegD,
    input  logic [NUM_SRC*REG_AW-1:0] iSrcRegE,
    input  logic                      iBranchTakenE,
    input  logic                      iMemReqM,
    input  logic                      iMemReadyM,
    output logic [NUM_SRC*2-1:0]      oForwardE,
    output logic                      oStallF,
    output logic                      oStallD,
    output logic                      oStallE,
    output logic                      oStallM,
    output logic                      oFlushD,
    output logic                      oFlushE,
    output logic                      oFlushW,
    output logic [CNT_W-1:0]          oStallCount
);

    // The bubble counter only has to hold LOAD_BUBBLES-1.
    localparam int BCNT_W = (LOAD_BUBBLES > 1) ? $clog2(LOAD_BUBBLES) : 1;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_MEM_WAIT   = 2'd2
    } state_t;

    state_t              state_q,     state_d;
    logic [BCNT_W-1:0]   bubble_q,    bubble_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

    logic load_use_hit;
    logic mem_wait;
    logic run_eval;

    // -------------------------------------------------------------------------
    // Forwarding selects for the operands of the instruction in E.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default before any branch.
        // Without it, a path that skips the assignment would infer a latch.
        oForwardE = '0;
        if (!iRst) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                if (iSrcRegE[k*REG_AW +: REG_AW] == '0) begin
                    oForwardE[k*2 +: 2] = 2'b00;
                end else if (iRegWriteEnM && (iDestRegM == iSrcRegE[k*REG_AW +: REG_AW])) begin
                    oForwardE[k*2 +: 2] = 2'b01;
                end else if (iRegWriteEnW && (iDestRegW == iSrcRegE[k*REG_AW +: REG_AW])) begin
                    oForwardE[k*2 +: 2] = 2'b10;
                end else begin
                    oForwardE[k*2 +: 2] = 2'b00;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Load-use detection. A load in E feeds a source operand that is in D.
    // -------------------------------------------------------------------------
    always_comb begin
        load_use_hit = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (iSrcRegD[k*REG_AW +: REG_AW] == iDestRegE) begin
                load_use_hit = 1'b1;
            end
        end
        load_use_hit = load_use_hit && iIsLoadE && iRegWriteEnE && (iDestRegE != '0);
    end

    assign mem_wait = iMemReqM && !iMemReadyM;

    // -------------------------------------------------------------------------
    // Next-state logic and stall/flush outputs.
    // The cycle in which MEM_WAIT sees ready counts as an ordinary RUN cycle.
    // A branch or load-use that waited in E is acted on in that same cycle,
    // because the pipeline advances as soon as the stalls drop.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        bubble_d = bubble_q;
        run_eval = 1'b0;
        oStallF  = 1'b0;
        oStallD  = 1'b0;
        oStallE  = 1'b0;
        oStallM  = 1'b0;
        oFlushD  = 1'b0;
        oFlushE  = 1'b0;
        oFlushW  = 1'b0;

        if (iRst) begin
            // Reset flushes the pipeline that cycle. The registered state
            // returns to RUN in the flop process.
            oFlushD = 1'b1;
            oFlushE = 1'b1;
            oFlushW = 1'b1;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (mem_wait) begin
                        state_d = ST_MEM_WAIT;
                    end else begin
                        run_eval = 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    if (iMemReadyM) begin
                        run_eval = 1'b1;
                    end
                end
                ST_LOAD_STALL: begin
                    // A memory wait pauses the bubble sequence. The counter
                    // holds its value.
                    if (!mem_wait) begin
                        oStallF  = 1'b1;
                        oStallD  = 1'b1;
                        oFlushE  = 1'b1;
                        bubble_d = bubble_q - BCNT_W'(1);
                        if (bubble_q == BCNT_W'(1)) begin
                            state_d = ST_RUN;
                        end
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase

            // Memory-wait outputs. This covers RUN and LOAD_STALL with a
            // pending request, and MEM_WAIT until the ready cycle.
            if (!run_eval && (mem_wait || (state_q == ST_MEM_WAIT))) begin
                oStallF = 1'b1;
                oStallD = 1'b1;
                oStallE = 1'b1;
                oStallM = 1'b1;
                oFlushW = 1'b1;
            end

            if (run_eval) begin
                state_d = ST_RUN;
                if (load_use_hit) begin
                    oStallF = 1'b1;
                    oStallD = 1'b1;
                    oFlushE = 1'b1;
                    if (LOAD_BUBBLES > 1) begin
                        state_d  = ST_LOAD_STALL;
                        bubble_d = BCNT_W'(LOAD_BUBBLES - 1);
                    end
                end else if (iBranchTakenE) begin
                    oFlushD = 1'b1;
                    oFlushE = 1'b1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Saturating count of cycles in which the PC was held.
    // -------------------------------------------------------------------------
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (oStallF && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    assign oStallCount = stall_cnt_q;

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q     <= ST_RUN;
            bubble_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            bubble_q    <= bubble_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_multicycle.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl_multicycle
//
// Directed bench for hazard_ctrl_multicycle. It uses two instances that share
// one stimulus:
//   dut_a : default parameters (LOAD_BUBBLES=1, CNT_W=16)
//   dut_b : LOAD_BUBBLES=3, CNT_W=3 (a narrow counter so saturation is reachable)
// Control outputs are packed as {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl_multicycle;

    localparam int REG_AW  = 5;
    localparam int NUM_SRC = 2;

    localparam logic [6:0] C_IDLE = 7'b000_0000;
    localparam logic [6:0] C_LOAD = 7'b110_0010;
    localparam logic [6:0] C_MEM  = 7'b111_1001;
    localparam logic [6:0] C_BR   = 7'b000_0110;
    localparam logic [6:0] C_RST  = 7'b000_0111;

    logic                      iClk = 1'b0;
    logic                      iRst;
    logic                      iIsLoadE, iRegWriteEnE, iRegWriteEnM, iRegWriteEnW;
    logic [REG_AW-1:0]         iDestRegE, iDestRegM, iDestRegW;
    logic [NUM_SRC*REG_AW-1:0] iSrcRegD, iSrcRegE;
    logic                      iBranchTakenE, iMemReqM, iMemReadyM;

    logic [NUM_SRC*2-1:0] a_fwd, b_fwd;
    logic a_sf, a_sd, a_se, a_sm, a_fd, a_fe, a_fw;
    logic b_sf, b_sd, b_se, b_sm, b_fd, b_fe, b_fw;
    logic [15:0] a_cnt;
    logic [2:0]  b_cnt;
    logic [6:0]  a_ctl, b_ctl;

    assign a_ctl = {a_sf, a_sd, a_se, a_sm, a_fd, a_fe, a_fw};
    assign b_ctl = {b_sf, b_sd, b_se, b_sm, b_fd, b_fe, b_fw};

    int total = 0;
    int bad   = 0;

    always #5 iClk = ~iClk;

    hazard_ctrl_multicycle #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC),
                             .LOAD_BUBBLES(1), .CNT_W(16)) dut_a (
        .iClk(iClk), .iRst(iRst), .iIsLoadE(iIsLoadE),
        .iRegWriteEnE(iRegWriteEnE), .iRegWriteEnM(iRegWriteEnM), .iRegWriteEnW(iRegWriteEnW),
        .iDestRegE(iDestRegE), .iDestRegM(iDestRegM), .iDestRegW(iDestRegW),
        .iSrcRegD(iSrcRegD), .iSrcRegE(iSrcRegE), .iBranchTakenE(iBranchTakenE),
        .iMemReqM(iMemReqM), .iMemReadyM(iMemReadyM), .oForwardE(a_fwd),
        .oStallF(a_sf), .oStallD(a_sd), .oStallE(a_se), .oStallM(a_sm),
        .oFlushD(a_fd), .oFlushE(a_fe), .oFlushW(a_fw), .oStallCount(a_cnt));

    hazard_ctrl_multicycle #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC),
                             .LOAD_BUBBLES(3), .CNT_W(3)) dut_b (
        .iClk(iClk), .iRst(iRst), .iIsLoadE(iIsLoadE),
        .iRegWriteEnE(iRegWriteEnE), .iRegWriteEnM(iRegWriteEnM), .iRegWriteEnW(iRegWriteEnW),
        .iDestRegE(iDestRegE), .iDestRegM(iDestRegM), .iDestRegW(iDestRegW),
        .iSrcRegD(iSrcRegD), .iSrcRegE(iSrcRegE), .iBranchTakenE(iBranchTakenE),
        .iMemReqM(iMemReqM), .iMemReadyM(iMemReadyM), .oForwardE(b_fwd),
        .oStallF(b_sf), .oStallD(b_sd), .oStallE(b_se), .oStallM(b_sm),
        .oFlushD(b_fd), .oFlushE(b_fe), .oFlushW(b_fw), .oStallCount(b_cnt));

    // Inputs change 1 time unit after the rising edge. Checks happen 2 units
    // after that, well away from either clock edge.
    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic set_idle();
        iIsLoadE = 0; iRegWriteEnE = 0; iRegWriteEnM = 0; iRegWriteEnW = 0;
        iDestRegE = '0; iDestRegM = '0; iDestRegW = '0;
        iSrcRegD = '0; iSrcRegE = '0;
        iBranchTakenE = 0; iMemReqM = 0; iMemReadyM = 0;
    endtask

    task automatic do_reset();
        set_idle();
        iRst = 1;
        tick();
        iRst = 0;
    endtask

    task automatic drive_load_x3();
        iIsLoadE = 1; iRegWriteEnE = 1; iDestRegE = 5'd3;
        iSrcRegD = {5'd3, 5'd0};
    endtask

    task automatic test_reset();
        // Reset outputs take priority over live forwarding and hazard inputs.
        set_idle();
        iRst = 1;
        iRegWriteEnM = 1; iDestRegM = 5'd5; iSrcRegE = {5'd5, 5'd5};
        iMemReqM = 1;
        settle();
        total++;
        if (a_ctl !== C_RST) begin bad++; $display("FAIL reset_ctl_a got=%b exp=%b", a_ctl, C_RST); end
        total++;
        if (a_fwd !== 4'b0000) begin bad++; $display("FAIL reset_fwd_a got=%b exp=0000", a_fwd); end
        tick();
        set_idle();
        iRst = 0;
        settle();
        total++;
        if (a_ctl !== C_IDLE || b_ctl !== C_IDLE) begin
            bad++; $display("FAIL post_reset_ctl got_a=%b got_b=%b exp=%b", a_ctl, b_ctl, C_IDLE);
        end
        total++;
        if (a_cnt !== 16'd0 || b_cnt !== 3'd0) begin
            bad++; $display("FAIL post_reset_cnt got_a=%0d got_b=%0d exp=0", a_cnt, b_cnt);
        end
    endtask

    task automatic test_forwarding();
        logic [4:0] dm [4];
        logic       wm [4];
        logic [4:0] dw [4];
        logic       ww [4];
        logic [9:0] se [4];
        logic [3:0] ex [4];
        // M beats W on operand 0, no match on operand 1.
        dm[0] = 5; wm[0] = 1; dw[0] = 5; ww[0] = 1; se[0] = {5'd9, 5'd5}; ex[0] = 4'b0001;
        // M not writing, so both operands come from W.
        dm[1] = 5; wm[1] = 0; dw[1] = 5; ww[1] = 1; se[1] = {5'd5, 5'd5}; ex[1] = 4'b1010;
        // x0 is never forwarded, even when M "writes" x0.
        dm[2] = 0; wm[2] = 1; dw[2] = 7; ww[2] = 1; se[2] = {5'd7, 5'd0}; ex[2] = 4'b1000;
        // Both operands from M, with W shadowed.
        dm[3] = 3; wm[3] = 1; dw[3] = 3; ww[3] = 1; se[3] = {5'd3, 5'd3}; ex[3] = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            set_idle();
            iDestRegM = dm[i]; iRegWriteEnM = wm[i];
            iDestRegW = dw[i]; iRegWriteEnW = ww[i];
            iSrcRegE  = se[i];
            settle();
            total++;
            if (a_fwd !== ex[i] || b_fwd !== ex[i]) begin
                bad++; $display("FAIL fwd_vec%0d got_a=%b got_b=%b exp=%b", i, a_fwd, b_fwd, ex[i]);
            end
            tick();
        end
    endtask

    task automatic test_load_use();
        do_reset();
        drive_load_x3();
        settle();
        total++;
        if (a_ctl !== C_LOAD || b_ctl !== C_LOAD) begin
            bad++; $display("FAIL lu_hit got_a=%b got_b=%b exp=%b", a_ctl, b_ctl, C_LOAD);
        end
        tick();
        set_idle();
        // Bubble 2 is on dut_b only. dut_a has already returned to RUN.
        settle();
        total++;
        if (a_ctl !== C_IDLE) begin bad++; $display("FAIL lu1_release got=%b exp=%b", a_ctl, C_IDLE); end
        total++;
        if (a_cnt !== 16'd1) begin bad++; $display("FAIL lu1_count got=%0d exp=1", a_cnt); end
        total++;
        if (b_ctl !== C_LOAD) begin bad++; $display("FAIL lu3_bubble2 got=%b exp=%b", b_ctl, C_LOAD); end
        tick();
        settle();
        total++;
        if (b_ctl !== C_LOAD) begin bad++; $display("FAIL lu3_bubble3 got=%b exp=%b", b_ctl, C_LOAD); end
        tick();
        settle();
        total++;
        if (b_ctl !== C_IDLE) begin bad++; $display("FAIL lu3_release got=%b exp=%b", b_ctl, C_IDLE); end
        total++;
        if (b_cnt !== 3'd3) begin bad++; $display("FAIL lu3_count got=%0d exp=3", b_cnt); end
        // No hazard when the load targets x0 or the load does not write.
        iIsLoadE = 1; iRegWriteEnE = 1; iDestRegE = 5'd0; iSrcRegD = {5'd0, 5'd0};
        settle();
        total++;
        if (a_ctl !== C_IDLE) begin bad++; $display("FAIL lu_x0 got=%b exp=%b", a_ctl, C_IDLE); end
        iRegWriteEnE = 0; iDestRegE = 5'd3; iSrcRegD = {5'd3, 5'd0};
        settle();
        total++;
        if (a_ctl !== C_IDLE) begin bad++; $display("FAIL lu_nowrite got=%b exp=%b", a_ctl, C_IDLE); end
        tick();
    endtask

    task automatic test_mem_wait();
        do_reset();
        iMemReqM = 1; iMemReadyM = 0;
        for (int i = 0; i < 4; i++) begin
            settle();
            total++;
            if (a_ctl !== C_MEM || b_ctl !== C_MEM) begin
                bad++; $display("FAIL mem_wait_c%0d got_a=%b got_b=%b exp=%b", i, a_ctl, b_ctl, C_MEM);
            end
            tick();
        end
        // Ready cycle: the stalls drop in this same cycle.
        iMemReadyM = 1;
        settle();
        total++;
        if (a_ctl !== C_IDLE) begin bad++; $display("FAIL mem_ready got=%b exp=%b", a_ctl, C_IDLE); end
        tick();
        set_idle();
        settle();
        total++;
        if (a_ctl !== C_IDLE) begin bad++; $display("FAIL mem_after got=%b exp=%b", a_ctl, C_IDLE); end
        total++;
        if (a_cnt !== 16'd4 || b_cnt !== 3'd4) begin
            bad++; $display("FAIL mem_count got_a=%0d got_b=%0d exp=4", a_cnt, b_cnt);
        end
        tick();
    endtask

    task automatic test_branch();
        do_reset();
        iBranchTakenE = 1;
        settle();
        total++;
        if (a_ctl !== C_BR) begin bad++; $display("FAIL br_run got=%b exp=%b", a_ctl, C_BR); end
        tick();
        // A branch under memory wait is held and does not flush.
        iMemReqM = 1; iMemReadyM = 0;
        for (int i = 0; i < 2; i++) begin
            settle();
            total++;
            if (a_ctl !== C_MEM) begin bad++; $display("FAIL br_memwait_c%0d got=%b exp=%b", i, a_ctl, C_MEM); end
            tick();
        end
        iMemReadyM = 1;
        settle();
        total++;
        if (a_ctl !== C_BR) begin bad++; $display("FAIL br_release got=%b exp=%b", a_ctl, C_BR); end
        tick();
        set_idle();
        settle();
        total++;
        if (a_ctl !== C_IDLE) begin bad++; $display("FAIL br_single got=%b exp=%b", a_ctl, C_IDLE); end
        tick();
    endtask

    task automatic test_mem_in_load_stall();
        do_reset();
        drive_load_x3();
        tick();
        set_idle();
        // dut_b is in LOAD_STALL with 2 bubbles left when the memory wait starts.
        iMemReqM = 1; iMemReadyM = 0;
        for (int i = 0; i < 2; i++) begin
            settle();
            total++;
            if (b_ctl !== C_MEM) begin bad++; $display("FAIL ls_memwait_c%0d got=%b exp=%b", i, b_ctl, C_MEM); end
            tick();
        end
        iMemReadyM = 1;
        settle();
        total++;
        if (b_ctl !== C_LOAD || a_ctl !== C_IDLE) begin
            bad++; $display("FAIL ls_resume got_b=%b exp_b=%b got_a=%b exp_a=%b", b_ctl, C_LOAD, a_ctl, C_IDLE);
        end
        tick();
        set_idle();
        settle();
        total++;
        if (b_ctl !== C_LOAD) begin bad++; $display("FAIL ls_last_bubble got=%b exp=%b", b_ctl, C_LOAD); end
        tick();
        settle();
        total++;
        if (b_ctl !== C_IDLE) begin bad++; $display("FAIL ls_done got=%b exp=%b", b_ctl, C_IDLE); end
        total++;
        if (b_cnt !== 3'd5 || a_cnt !== 16'd3) begin
            bad++; $display("FAIL ls_count got_b=%0d exp_b=5 got_a=%0d exp_a=3", b_cnt, a_cnt);
        end
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        iMemReqM = 1; iMemReadyM = 0;
        for (int i = 0; i < 9; i++) tick();
        settle();
        total++;
        if (b_cnt !== 3'd7) begin bad++; $display("FAIL sat_b got=%0d exp=7", b_cnt); end
        total++;
        if (a_cnt !== 16'd9) begin bad++; $display("FAIL sat_a_nosat got=%0d exp=9", a_cnt); end
        iMemReadyM = 1;
        tick();
        set_idle();
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        drive_load_x3();
        tick();
        set_idle();
        // dut_b is on its second bubble when reset is asserted.
        iRst = 1;
        settle();
        total++;
        if (b_ctl !== C_RST) begin bad++; $display("FAIL rst_mid_ctl got=%b exp=%b", b_ctl, C_RST); end
        tick();
        iRst = 0;
        settle();
        total++;
        if (b_ctl !== C_IDLE) begin bad++; $display("FAIL rst_mid_after got=%b exp=%b", b_ctl, C_IDLE); end
        total++;
        if (b_cnt !== 3'd0) begin bad++; $display("FAIL rst_mid_cnt got=%0d exp=0", b_cnt); end
        tick();
    endtask

    initial begin
        set_idle();
        iRst = 1;
        tick();
        test_reset();
        test_forwarding();
        test_load_use();
        test_mem_wait();
        test_branch();
        test_mem_in_load_stall();
        test_saturation();
        test_reset_mid_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
